// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - APB wait-state slave: FSM state type, default parameters, wait clamp helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int MAX_WAIT_DEF = 7;

  function automatic int clamp_wait(input int cfg, input int max_wait);
    return (cfg > max_wait) ? max_wait : cfg;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// rtl/apb_wait_ctr.sv - Wait-state down counter with load, decrement and zero flag.
module apb_wait_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slave_ws.sv
// rtl/apb_slave_ws.sv - APB register-file slave with programmable wait states and byte strobes.
// Optional macro APB_SLVERR_EN: flag out-of-range accesses on pslverr.
module apb_slave_ws
  import apb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cfg,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     strb_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ctr_zero;
  logic [WAIT_W-1:0] wait_load;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;

  assign wait_load = WAIT_W'(clamp_wait(int'(wait_cfg), MAX_WAIT));
  assign in_range  = int'(addr_q) < DEPTH;
  assign idx       = addr_q[IDX_W-1:0];

  apb_wait_ctr #(.W(WAIT_W)) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (state == SETUP),
    .dec      (state == ACCESS),
    .load_val (wait_load),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // penable in IDLE is a protocol violation and simply ignored
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (psel && !penable) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (pready || !psel) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state == SETUP) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  assign pready = (state == ACCESS) && ctr_zero;
  assign wr_en  = pready && write_q && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign prdata = (pready && !write_q && in_range) ? mem[idx] : '0;

`ifdef APB_SLVERR_EN
  assign pslverr = pready && !in_range;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_ws.sv
// tb/tb_apb_slave_ws.sv - Randomized self-checking bench for apb_slave_ws against a register-file model.
module tb_apb_slave_ws;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int MAXW   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [15:0] pwdata = '0;
  logic [1:0]  pstrb = '0;
  logic [2:0]  wait_cfg = '0;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_mem [DEPTH];

  apb_slave_ws #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .wait_cfg(wait_cfg),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  function automatic logic exp_err(input logic [3:0] a);
`ifdef APB_SLVERR_EN
    return (int'(a) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_read(input logic [3:0] a);
    return (int'(a) < DEPTH) ? exp_mem[a[2:0]] : 16'h0;
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
    if (int'(a) < DEPTH) begin
      if (s[0]) exp_mem[a[2:0]][7:0]  = d[7:0];
      if (s[1]) exp_mem[a[2:0]][15:8] = d[15:8];
    end
  endtask

  // Full bus transfer; cyc counts the SETUP cycle plus every ACCESS cycle up to pready (-1 on timeout).
  // bad flags pready in SETUP or nonzero prdata/pslverr while pready is low.
  task automatic do_xfer(input logic wr, input logic [3:0] a, input logic [15:0] d,
                         input logic [1:0] s, input logic [2:0] wc,
                         output logic [15:0] rd, output logic err, output int cyc, output logic bad);
    bad = 1'b0;
    rd  = '0;
    err = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; wait_cfg = wc;
    @(posedge clk); #1;
    penable = 1'b1;
    if (pready !== 1'b0) bad = 1'b1;
    cyc = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (pready === 1'b1) begin
        rd  = prdata;
        err = pslverr;
        if (wr) model_write(a, d, s);
        return;
      end
      if (prdata !== 16'h0 || pslverr !== 1'b0) bad = 1'b1;
    end
    cyc = -1;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  task automatic test_reset();
    logic [15:0] rd; logic err, bad; int cyc;
    apply_reset();
    n_tests++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: pready=%b pslverr=%b prdata=%h required 0/0/0000", pready, pslverr, prdata);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_xfer(1'b0, 4'(i), 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
      n_tests++;
      if (rd !== 16'h0 || cyc !== 2 || bad !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mem[%0d]: data=%h cycles=%0d bad=%b required 0000/2/0", i, rd, cyc, bad);
      end
    end
    bus_idle();
  endtask

  task automatic test_basic();
    logic [15:0] rd; logic err, bad; int cyc;
    do_xfer(1'b1, 4'd3, 16'h00A5, 2'b11, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (cyc !== 2 || bad !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_write: cycles=%0d bad=%b err=%b required 2/0/0", cyc, bad, err);
    end
    do_xfer(1'b0, 4'd3, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h00A5 || cyc !== 2 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_read: data=%h cycles=%0d bad=%b required 00a5/2/0", rd, cyc, bad);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [15:0] rd; logic err, bad; int cyc;
    do_xfer(1'b0, 4'd3, 16'h0, 2'b00, 3'd3, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h00A5 || cyc !== 5 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL wait3_read: data=%h cycles=%0d bad=%b required 00a5/5/0", rd, cyc, bad);
    end
    do_xfer(1'b0, 4'd3, 16'h0, 2'b00, 3'd7, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h00A5 || cyc !== 9 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL wait7_read: data=%h cycles=%0d bad=%b required 00a5/9/0", rd, cyc, bad);
    end
    bus_idle();
  endtask

  task automatic test_strobe();
    logic [15:0] rd; logic err, bad; int cyc;
    do_xfer(1'b1, 4'd1, 16'h1234, 2'b11, 3'd1, rd, err, cyc, bad);
    do_xfer(1'b1, 4'd1, 16'hABCD, 2'b01, 3'd0, rd, err, cyc, bad);
    do_xfer(1'b0, 4'd1, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h12CD || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_lo: data=%h bad=%b required 12cd/0", rd, bad);
    end
    do_xfer(1'b1, 4'd1, 16'h5678, 2'b10, 3'd2, rd, err, cyc, bad);
    do_xfer(1'b0, 4'd1, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h56CD) begin
      n_fail++;
      $display("FAIL strobe_hi: data=%h required 56cd", rd);
    end
    bus_idle();
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic err, bad; int cyc;
    do_xfer(1'b1, 4'd12, 16'hFFFF, 2'b11, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (err !== exp_err(4'd12) || cyc !== 2) begin
      n_fail++;
      $display("FAIL oor_write: pslverr=%b cycles=%0d required %b/2", err, cyc, exp_err(4'd12));
    end
    do_xfer(1'b0, 4'd12, 16'h0, 2'b00, 3'd1, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h0 || err !== exp_err(4'd12)) begin
      n_fail++;
      $display("FAIL oor_read: data=%h pslverr=%b required 0000/%b", rd, err, exp_err(4'd12));
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_xfer(1'b0, 4'(i), 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
      n_tests++;
      if (rd !== exp_mem[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_mem[%0d]: data=%h pslverr=%b required %h/0", i, rd, err, exp_mem[i]);
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic err, bad; int cyc;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd5; pwdata = 16'hBEEF; pstrb = 2'b11; wait_cfg = 3'd5;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    n_tests++;
    if (pready !== 1'b0 || prdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_out: pready=%b prdata=%h required 0/0000", pready, prdata);
    end
    do_xfer(1'b0, 4'd5, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h0 || cyc !== 2 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mem: data=%h cycles=%0d bad=%b required 0000/2/0", rd, cyc, bad);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [15:0] rd; logic err, bad; int cyc;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 16'h7E57; pstrb = 2'b11; wait_cfg = 3'd2;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (pready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_access1: pready=%b required 0", pready);
    end
    psel = 1'b0; penable = 1'b0;
    do_xfer(1'b0, 4'd2, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== exp_read(4'd2) || cyc !== 2 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_b2b: data=%h cycles=%0d bad=%b required %h/2/0", rd, cyc, bad, exp_read(4'd2));
    end
    do_xfer(1'b1, 4'd2, 16'h1357, 2'b11, 3'd2, rd, err, cyc, bad);
    do_xfer(1'b0, 4'd2, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== 16'h1357 || cyc !== 2) begin
      n_fail++;
      $display("FAIL abort_recover: data=%h cycles=%0d required 1357/2", rd, cyc);
    end
    bus_idle();
  endtask

  task automatic test_penable_idle();
    logic [15:0] rd; logic err, bad; int cyc;
    bit seen = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 16'hDEAD; pstrb = 2'b11; wait_cfg = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (pready !== 1'b0) seen = 1'b1;
    end
    psel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (pready !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL penable_idle: pready seen=%b required 0", seen);
    end
    do_xfer(1'b0, 4'd0, 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
    n_tests++;
    if (rd !== exp_read(4'd0) || cyc !== 2) begin
      n_fail++;
      $display("FAIL penable_idle_mem: data=%h cycles=%0d required %h/2", rd, cyc, exp_read(4'd0));
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [15:0] rd, d, exp_rd; logic err, bad, wr; logic [3:0] a; logic [1:0] s; logic [2:0] wc; int cyc;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 16'($urandom);
      s  = 2'($urandom_range(0, 3));
      wc = 3'($urandom_range(0, 7));
      exp_rd = wr ? 16'h0 : exp_read(a);
      do_xfer(wr, a, d, s, wc, rd, err, cyc, bad);
      n_tests++;
      if (rd !== exp_rd || err !== exp_err(a) || cyc !== int'(wc) + 2 || bad !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] wr=%b a=%0d: data=%h err=%b cycles=%0d bad=%b required %h/%b/%0d/0",
                 n, wr, a, rd, err, cyc, bad, exp_rd, exp_err(a), int'(wc) + 2);
      end
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();
    for (int i = 0; i < DEPTH; i++) begin
      do_xfer(1'b0, 4'(i), 16'h0, 2'b00, 3'd0, rd, err, cyc, bad);
      n_tests++;
      if (rd !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL random_final[%0d]: data=%h required %h", i, rd, exp_mem[i]);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_strobe();
    test_out_of_range();
    test_reset_mid();
    test_abort();
    test_penable_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
